alu_exec: RTL
=============

Name: alu_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALUOP code produced by ALU control and performs the operation on two 32-bit operands.
- Single-cycle ops return a registered result one cycle after acceptance.
- MUL/DIV run on an iterative shift/add (subtract) engine, and the pipeline stalls through in_ready.
- Sits between the ID/EX register and the EX/MEM register. Also drives the branch-taken flag for BEQ/BNE.

Parameters:
- WIDTH, 32: operand/result width; also the MUL/DIV iteration count.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept (state IDLE)
- aluop  in  4  ALUOP_* code
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt or immediate)
- shamt  in  5  shift amount for SLL/SRL/SRA
- flush  in  1  abort in-flight op (pipeline squash)
- out_valid  out  1  one-cycle pulse, result valid
- result  out  WIDTH  registered result
- taken  out  1  branch condition true (BEQ/BNE only, else 0)
- err  out  1  pulses with out_valid for unknown aluop or divide by zero

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; result=0; taken=0; err=0; engine registers cleared.
- Accept rule: accept when in_valid && in_ready. in_ready=1 only in IDLE and not flush.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA, LUI, BEQ, BNE):
  - Accepted at edge N; result/out_valid visible after edge N+1; state stays IDLE.
  - Back-to-back issue at 1 op/cycle.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT is signed compare, result 1 or 0.
  - SLL/SRL/SRA use shamt; SRA is arithmetic.
  - LUI = {b[15:0], 16'b0}.
  - BEQ: taken=(a==b). BNE: taken=(a!=b). For both, result=a-b.
- MUL:
  - IDLE -> MUL on accept. Operands made magnitude, sign recorded.
  - WIDTH iterations of shift-add, then FIX applies sign; FIX -> IDLE with out_valid.
  - result = low WIDTH bits of the signed product.
  - Latency: out_valid exactly WIDTH+2 cycles after accept.
- DIV:
  - IDLE -> DIV -> FIX -> IDLE, restoring division, same WIDTH+2 latency.
  - result = signed quotient, truncated toward zero.
  - 0x80000000 / -1 returns 0x80000000, err=0.
  - b==0: no iteration; out_valid next cycle, result=all ones, err=1.
- Unknown aluop: out_valid next cycle, result=0, taken=0, err=1.
- flush:
  - In MUL/DIV/FIX: return to IDLE next edge; no out_valid; result holds its previous value.
  - In IDLE with in_valid: not accepted, since in_ready is forced 0.
- out_valid and err are single-cycle pulses. result holds until the next out_valid. taken is cleared on every out_valid that is not a branch.
- Iteration counter: log2(WIDTH)+1 bits, loaded with WIDTH-1, counts down to 0. No wrap is possible.

Decomposition:
- defines.v holds:
  - existing ALUOP_* codes;
  - new ALUEX_IDLE/MUL/DIV/FIX state encodings (2 bits);
  - DIV0_RESULT constant.
- Sub-module muldiv_iter: iterative core with start, op, a, b; provides busy, done, product/quotient. Contains the counter and the FIX step.
- alu_exec owns the single-cycle datapath, the handshake and output registers.

Test Plan:
- Reset asserted mid-MUL (cycle 10) -> next sample: in_ready=1, out_valid=0, result=0. A subsequent ADD 3+4 -> result=7 one cycle later.
- Back-to-back single-cycle ops:
  - Stimulus: SUB 5-7, SLT -1<1, SRA 0x80000000 shamt=4, LUI b=0x1234, on consecutive cycles.
  - Response: four consecutive out_valid pulses with results 0xFFFFFFFE, 1, 0xF8000000, 0x12340000.
- MUL -6*7 -> in_ready=0 for 34 cycles; out_valid at accept+34; result=0xFFFFFFD6. Repeat for DIV -7/2 -> result=0xFFFFFFFD.
- DIV 100/0 -> out_valid next cycle, result=0xFFFFFFFF, err=1. DIV 0x80000000/-1 -> result=0x80000000, err=0.
- BEQ a=b=0x55 -> taken=1, result=0. BNE same operands -> taken=0. Unknown aluop -> err=1, result=0.
- flush during DIV at accept+5 -> no out_valid in the next 40 cycles; result unchanged; in_ready=1 one cycle after flush deasserts.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - ALUOP codes, execute-unit state encodings and shared constants
package alu_exec_pkg;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_AND = 4'd2;
  localparam logic [3:0] ALUOP_OR  = 4'd3;
  localparam logic [3:0] ALUOP_XOR = 4'd4;
  localparam logic [3:0] ALUOP_NOR = 4'd5;
  localparam logic [3:0] ALUOP_SLT = 4'd6;
  localparam logic [3:0] ALUOP_SLL = 4'd7;
  localparam logic [3:0] ALUOP_SRL = 4'd8;
  localparam logic [3:0] ALUOP_SRA = 4'd9;
  localparam logic [3:0] ALUOP_LUI = 4'd10;
  localparam logic [3:0] ALUOP_BEQ = 4'd11;
  localparam logic [3:0] ALUOP_BNE = 4'd12;
  localparam logic [3:0] ALUOP_MUL = 4'd13;
  localparam logic [3:0] ALUOP_DIV = 4'd14;

  typedef enum logic [1:0] {
    ALUEX_IDLE = 2'd0,
    ALUEX_MUL  = 2'd1,
    ALUEX_DIV  = 2'd2,
    ALUEX_FIX  = 2'd3
  } aluex_state_e;

  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == ALUOP_BEQ) || (op == ALUOP_BNE);
  endfunction

endpackage

// File: rtl/alu_exec_muldiv_iter.sv
// rtl/alu_exec_muldiv_iter.sv - iterative signed shift-add multiplier / restoring divider
// Works on magnitudes; the FIX state reapplies the recorded sign.
module alu_exec_muldiv_iter
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  aluex_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             neg_q, neg_d;
  logic             div_q, div_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] mag;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // MUL: acc=product, x=multiplicand, y=multiplier. DIV: acc=remainder, x=dividend/quotient, y=divisor.
  assign rem_sh  = {acc_q, x_q[WIDTH-1]};
  assign rem_sub = rem_sh[WIDTH-1:0] - y_q;
  assign mag     = div_q ? x_q : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    neg_d   = neg_q;
    div_d   = div_q;
    done_d  = 1'b0;
    case (state_q)
      ALUEX_IDLE: begin
        if (start_i) begin
          state_d = op_div_i ? ALUEX_DIV : ALUEX_MUL;
          div_d   = op_div_i;
          neg_d   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
          acc_d   = '0;
          x_d     = abs_val(a_i);
          y_d     = abs_val(b_i);
          cnt_d   = CNT_LOAD;
        end
      end
      ALUEX_MUL: begin
        if (y_q[0]) acc_d = acc_q + x_q;
        x_d = x_q << 1;
        y_d = y_q >> 1;
        if (cnt_q == '0) state_d = ALUEX_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ALUEX_DIV: begin
        x_d = {x_q[WIDTH-2:0], 1'b0};
        if (rem_sh >= {1'b0, y_q}) begin
          acc_d  = rem_sub;
          x_d[0] = 1'b1;
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
        end
        if (cnt_q == '0) state_d = ALUEX_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ALUEX_FIX: begin
        res_d   = neg_q ? -mag : mag;
        done_d  = 1'b1;
        state_d = ALUEX_IDLE;
      end
      default: state_d = ALUEX_IDLE;
    endcase
    if (flush_i) begin
      state_d = ALUEX_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ALUEX_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      div_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  assign busy_o   = (state_q != ALUEX_IDLE);
  assign done_o   = done_q;
  assign result_o = res_q;

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute-stage ALU: single-cycle datapath, handshake, output registers
// Accepted single-cycle ops pass through one operand stage before the output register.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       aluop_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       shamt_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             taken_o,
  output logic             err_o
);

  logic             md_busy, md_done, md_start;
  logic [WIDTH-1:0] md_result;
  logic             accept, use_engine;

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]       sh_q, sh_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_taken, alu_err;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             taken_q, taken_d;
  logic             err_q, err_d;

  assign in_ready_o = !md_busy && !md_done && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  // Divide by zero never enters the engine; it completes like a single-cycle op.
  assign use_engine = (aluop_i == ALUOP_MUL) || ((aluop_i == ALUOP_DIV) && (b_i != '0));
  assign md_start   = accept && use_engine;

  alu_exec_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (md_start),
    .op_div_i (aluop_i == ALUOP_DIV),
    .flush_i  (flush_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_comb begin
    s1_valid_d = accept && !use_engine;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sh_d       = sh_q;
    if (accept) begin
      op_d = aluop_i;
      a_d  = a_i;
      b_d  = b_i;
      sh_d = shamt_i;
    end
  end

  always_comb begin
    alu_res   = '0;
    alu_taken = 1'b0;
    alu_err   = 1'b0;
    case (op_q)
      ALUOP_ADD: alu_res = a_q + b_q;
      ALUOP_SUB: alu_res = a_q - b_q;
      ALUOP_AND: alu_res = a_q & b_q;
      ALUOP_OR:  alu_res = a_q | b_q;
      ALUOP_XOR: alu_res = a_q ^ b_q;
      ALUOP_NOR: alu_res = ~(a_q | b_q);
      ALUOP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      ALUOP_SLL: alu_res = a_q << sh_q;
      ALUOP_SRL: alu_res = a_q >> sh_q;
      ALUOP_SRA: alu_res = $unsigned($signed(a_q) >>> sh_q);
      ALUOP_LUI: alu_res = {b_q[15:0], {(WIDTH-16){1'b0}}};
      ALUOP_BEQ: begin
        alu_res   = a_q - b_q;
        alu_taken = (a_q == b_q);
      end
      ALUOP_BNE: begin
        alu_res   = a_q - b_q;
        alu_taken = (a_q != b_q);
      end
      ALUOP_DIV: begin
        alu_res = DIV0_RESULT[WIDTH-1:0];
        alu_err = 1'b1;
      end
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    result_d    = result_q;
    taken_d     = taken_q;
    if (md_done && !flush_i) begin
      out_valid_d = 1'b1;
      result_d    = md_result;
      taken_d     = 1'b0;
    end else if (s1_valid_q) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      taken_d     = is_branch(op_q) && alu_taken;
      err_d       = alu_err;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q  <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sh_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sh_q        <= sh_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign taken_o     = taken_q;
  assign err_o       = err_q;

endmodule
